uart_tx_engine: RTL
===================

# uart_tx_engine

Parametrised UART transmit engine: frame FSM, serializer, parity generator and output bit mux in one block. It sits between the command/response datapath and the TX pin. Each accepted parallel word becomes one serial frame: start bit, DATA_WIDTH data bits LSB-first, optional even/odd parity, and one or two stop bits. One bit is sent per `clk` cycle; `clk` is the bit clock.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 1..16.
- `clk` input 1: bit clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `p_data` input DATA_WIDTH: parallel word to send.
- `data_valid` input 1: word request; accepted on an edge where `data_valid && !busy`.
- `par_en` input 1: 1 = insert a parity bit.
- `par_typ` input 1: 0 = even parity, 1 = odd parity.
- `stop2` input 1: 1 = two stop bits, 0 = one stop bit.
- `tx_out` output 1: serial line, registered, idles high.
- `busy` output 1: registered; accept-blocking indication.
- `frame_done` output 1: one-cycle pulse during the last stop bit of each frame.

## Operation
- FSM states and transitions:
  - IDLE → START on accept.
  - START → DATA after 1 cycle.
  - DATA → PARITY after DATA_WIDTH cycles, if `par_en` was latched; otherwise DATA → STOP.
  - PARITY → STOP after 1 cycle.
  - STOP → IDLE after 1 cycle, or 2 cycles if `stop2` was latched; goes to START instead when a held word exists (HOLD build only).
- Accept latches `p_data`, `par_en`, `par_typ` and `stop2`. Input changes mid-frame have no effect on the frame in progress.
- `tx_out` per state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift register LSB; the shift register shifts right each DATA cycle.
  - PARITY: XOR of the latched data, inverted when `par_typ` = 1.
  - STOP: 1.
- Frame length is 1 + DATA_WIDTH + `par_en` + (1 + `stop2`) bits.
- The bit counter is $clog2(DATA_WIDTH)+1 bits wide and is cleared on entry to DATA. There is no wrap-around inside a frame.
- Reset values: `tx_out` = 1, `busy` = 0, `frame_done` = 0, FSM = IDLE, hold register empty.
- Reset mid-frame aborts the frame immediately. The line goes high asynchronously and no `frame_done` pulse is produced.

## Timing
- Latency: accept at edge k → start bit on `tx_out` in cycle k+1 → first data bit in cycle k+2.
- `frame_done` is high in exactly the cycle in which the final stop bit is driven.
- Without HOLD:
  - `busy` rises in the cycle after accept and stays high through the last stop-bit cycle inclusive.
  - `data_valid` while `busy` is ignored, not queued.
  - The earliest next accept is in the first IDLE cycle, so back-to-back frames have exactly one idle bit between them.
- A `data_valid` pulse in the same cycle that `busy` falls is accepted; `busy` is low in that cycle.

## Configuration
- Macro: `UART_TX_HOLD_EN`.
- Defined: adds a one-word hold register holding `p_data` plus its config bits, and `busy` means "hold register full".
  - Accept while the FSM is in IDLE loads the shifter directly.
  - Accept while a frame is active loads the hold register.
  - In the last stop-bit cycle, a full hold register transfers to the shifter, the FSM enters START next cycle, and the hold register clears. The resulting gap between frames is zero idle bits.
  - `data_valid` in the transfer cycle is blocked, because `busy` is still registered high. It is accepted in the following cycle.
- Undefined: no hold register; `busy` covers the whole frame as described in Timing.

## Structure
- Package `uart_tx_pkg`:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - Parity-type constants PAR_EVEN = 0, PAR_ODD = 1.
  - Line level constants IDLE_LVL = 1, START_LVL = 0.
- Sub-module `uart_tx_serializer`: load, shift and bit-count logic, with a `ser_done` flag asserted on the last data bit. The engine instantiates one.

## Test plan
- DATA_WIDTH = 8, `p_data` = 0xA5, `par_en` = 1, `par_typ` = 0, `stop2` = 0 → `tx_out` = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles starting at k+1; `frame_done` pulses in cycle k+11.
- Same word with `par_typ` = 1 and `stop2` = 1 → parity bit = 1, then two stop bits; 12-bit frame; `busy` high for 12 cycles.
- `par_en` = 0, `p_data` = 0x00 → 0, eight 0s, then 1: a 10-bit frame. Toggling `p_data` mid-frame leaves the output unchanged.
- Without HOLD, `data_valid` held high for 30 cycles → frames separated by exactly one high idle bit; no word is dropped within the accept windows.
- With HOLD, issue 0x12 then 0x34 two cycles later → the 0x34 frame's start bit immediately follows the 0x12 frame's stop bit; `busy` is high from the second accept until the transfer.
- Assert `rst` = 0 during a data bit → `tx_out` goes to 1 asynchronously, `busy` = 0, no `frame_done`; a fresh accept afterwards produces a clean frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit engine.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data-bit shifter and bit counter for the UART transmit engine.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  shift,
    input  logic                  clr,
    input  logic                  inc,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (load)
                shreg <= ld_data;
            else if (shift)
                shreg <= shreg >> 1;
            if (clr)
                bit_cnt <= '0;
            else if (inc)
                bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign ser_bit  = shreg[0];
    assign ser_done = inc && (bit_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frame FSM, parity and registered line driver.
// Optional one-word hold register enabled by defining UART_TX_HOLD_EN.
module uart_tx_engine
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    tx_state_t state, next_state;

    logic                  accept, load_direct, xfer, load_frame, stop_last;
    logic                  par_en_l, stop2_l, par_bit, stop_cnt;
    logic                  tx_next, busy_next;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_par_en, src_par_typ, src_stop2;
    logic                  ser_bit, ser_done;

    assign accept    = data_valid && !busy;
    assign stop_last = (state == STOP) && (!stop2_l || stop_cnt);

`ifdef UART_TX_HOLD_EN
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_par_en, hold_par_typ, hold_stop2;

    // An accept in the last stop cycle with an empty hold goes straight to the shifter.
    assign load_direct = accept && ((state == IDLE) || stop_last);
    assign xfer        = stop_last && hold_full;
    assign busy_next   = (accept && !load_direct) || (hold_full && !xfer);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full    <= 1'b0;
            hold_data    <= '0;
            hold_par_en  <= 1'b0;
            hold_par_typ <= 1'b0;
            hold_stop2   <= 1'b0;
        end else if (accept && !load_direct) begin
            hold_full    <= 1'b1;
            hold_data    <= p_data;
            hold_par_en  <= par_en;
            hold_par_typ <= par_typ;
            hold_stop2   <= stop2;
        end else if (xfer) begin
            hold_full <= 1'b0;
        end
    end

    assign src_data    = xfer ? hold_data    : p_data;
    assign src_par_en  = xfer ? hold_par_en  : par_en;
    assign src_par_typ = xfer ? hold_par_typ : par_typ;
    assign src_stop2   = xfer ? hold_stop2   : stop2;
`else
    assign load_direct = accept;
    assign xfer        = 1'b0;
    assign busy_next   = (next_state != IDLE);
    assign src_data    = p_data;
    assign src_par_en  = par_en;
    assign src_par_typ = par_typ;
    assign src_stop2   = stop2;
`endif

    assign load_frame = load_direct || xfer;
    assign frame_done = stop_last;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load_frame) next_state = START;
            START:   next_state = DATA;
            DATA:    if (ser_done) next_state = par_en_l ? PARITY : STOP;
            PARITY:  next_state = STOP;
            STOP:    if (stop_last) next_state = load_frame ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // tx_out is registered, so it is driven from the state being entered.
    always_comb begin
        tx_next = IDLE_LVL;
        case (next_state)
            START:   tx_next = START_LVL;
            DATA:    tx_next = ser_bit;
            PARITY:  tx_next = par_bit;
            default: tx_next = IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_out   <= IDLE_LVL;
            busy     <= 1'b0;
            par_en_l <= 1'b0;
            stop2_l  <= 1'b0;
            par_bit  <= 1'b0;
            stop_cnt <= 1'b0;
        end else begin
            state    <= next_state;
            tx_out   <= tx_next;
            busy     <= busy_next;
            stop_cnt <= (state == STOP);
            if (load_frame) begin
                par_en_l <= src_par_en;
                stop2_l  <= src_stop2;
                par_bit  <= (^src_data) ^ (src_par_typ != PAR_EVEN);
            end
        end
    end

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load_frame),
        .ld_data  (src_data),
        .shift    (next_state == DATA),
        .clr      (state == START),
        .inc      (state == DATA),
        .ser_bit  (ser_bit),
        .ser_done (ser_done)
    );

endmodule
